// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// for R-type, beq, addi, ori, lw, sw and j, waits on memReady and traps memory
// timeouts into a sticky HALT state.
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes go through a TRAP state
// that pulses illegalOp; without it they are a silent NOP.
module multicycle_control #(
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [5:0] opCode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       branch,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluOp,
  output logic [1:0] pcSrc,
  output logic       instrDone,
  output logic       memErr,
`ifdef ILLEGAL_TRAP_EN
  output logic       illegalOp,
`endif
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_VAL = TIMEOUT_W'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC_R = 4'd7,
    RWB    = 4'd8,
    EXEC_I = 4'd9,
    IWB    = 4'd10,
    BRANCH = 4'd11,
    JUMP   = 4'd12,
    HALT   = 4'd13,
    TRAP   = 4'd14
  } state_t;

  state_t                state_q, state_d;
  logic [TIMEOUT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic                  mem_err_q, mem_err_d;
  logic                  timed_out;

  // Last permitted wait cycle of a memory state with the access still pending.
  assign timed_out = (wait_cnt_q == TIMEOUT_VAL) && !memReady;

  // State, wait counter and sticky error registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= INIT;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Next-state and control decode; the counter restarts from 0 on every
  // state change, so it is always clear on entry to a memory state.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    mem_err_d  = mem_err_q;
    pcWrite    = 1'b0;
    branch     = 1'b0;
    iorD       = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    memToReg   = 1'b0;
    regDst     = 1'b0;
    regWrite   = 1'b0;
    aluSrcA    = 1'b0;
    aluSrcB    = 2'b00;
    aluOp      = 3'b000;
    pcSrc      = 2'b00;
    instrDone  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegalOp  = 1'b0;
`endif
    case (state_q)
      INIT: state_d = FETCH;
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcWrite = memReady;
        if (memReady) begin
          state_d = DECODE;
        end else if (timed_out) begin
          state_d   = HALT;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      DECODE: begin
        aluSrcB = 2'b11;
        case (opCode)
          OP_RTYPE:       state_d = EXEC_R;
          OP_LW, OP_SW:   state_d = MEMADR;
          OP_BEQ:         state_d = BRANCH;
          OP_ADDI, OP_ORI: state_d = EXEC_I;
          OP_J:           state_d = JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:        state_d = TRAP;
`else
          default:        state_d = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = (opCode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD, MEMWR: begin
        iorD     = 1'b1;
        memRead  = (state_q == MEMRD);
        memWrite = (state_q == MEMWR);
        instrDone = (state_q == MEMWR) && memReady;
        if (memReady) begin
          state_d = (state_q == MEMRD) ? MEMWB : FETCH;
        end else if (timed_out) begin
          state_d   = HALT;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      MEMWB: begin
        memToReg  = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
        state_d   = FETCH;
      end
      EXEC_R: begin
        aluSrcA = 1'b1;
        aluOp   = 3'b010;
        state_d = RWB;
      end
      RWB: begin
        regDst    = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
        state_d   = FETCH;
      end
      EXEC_I: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        aluOp   = (opCode == OP_ORI) ? 3'b100 : 3'b000;
        state_d = IWB;
      end
      IWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        aluSrcA   = 1'b1;
        aluOp     = 3'b001;
        pcSrc     = 2'b01;
        branch    = 1'b1;
        instrDone = 1'b1;
        state_d   = FETCH;
      end
      JUMP: begin
        pcSrc     = 2'b10;
        pcWrite   = 1'b1;
        instrDone = 1'b1;
        state_d   = FETCH;
      end
      HALT: state_d = HALT;
`ifdef ILLEGAL_TRAP_EN
      TRAP: begin
        illegalOp = 1'b1;
        state_d   = FETCH;
      end
`endif
      default: state_d = INIT;
    endcase
  end

  assign memErr = mem_err_q;
  assign state  = state_q;

endmodule
